grid_frame_renderer: RTL

- Reads the 28x28 one-bit drawing memory cell by cell and issues 4x4-pixel plot commands to the vga_adapter at 160x120, redrawing the whole grid on request.
- It is the read/display side of the cursor-draw memory: the draw logic writes cells, and this block scans them out to the framebuffer.
- It also overlays the cursor cell in a distinct colour.
- It sits between the pixel memory's synchronous read port and vga_adapter's x/y/colour/plot inputs.

---
 rtl/grid_frame_renderer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/grid_frame_renderer.sv
// Scans the 28x28 one-bit drawing memory out to vga_adapter as 4x4 pixel chunks,
// drawing the latched cursor cell in its own colour.
module grid_frame_renderer #(
  parameter int         GRID_SIZE     = 28,
  parameter int         CHUNK_SIZE    = 4,
  parameter int         OFFSET_X      = 10,
  parameter int         OFFSET_Y      = 4,
  parameter logic [2:0] ON_COLOUR     = 3'b111,
  parameter logic [2:0] OFF_COLOUR    = 3'b000,
  parameter logic [2:0] CURSOR_COLOUR = 3'b100
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  input  logic [4:0] cursor_x,
  input  logic [4:0] cursor_y,
  output logic [9:0] mem_addr,
  input  logic       mem_rdata,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_PLOT  = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam int                SUB_W     = (CHUNK_SIZE > 1) ? $clog2(CHUNK_SIZE) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(CHUNK_SIZE - 1);
  localparam logic [4:0]       CELL_LAST = 5'(GRID_SIZE - 1);

  logic [2:0]       state;
  logic [4:0]       cell_x, cell_y;
  logic [SUB_W-1:0] sub_x, sub_y;
  logic [4:0]       cur_x, cur_y;

  logic [SUB_W-1:0] nsub_x, nsub_y;
  logic [4:0]       ncell_x, ncell_y;
  logic             chunk_end, last_cell;

  function automatic logic [7:0] pix_x(input logic [4:0] c, input logic [SUB_W-1:0] s);
    int v;
    v = OFFSET_X + int'(c) * CHUNK_SIZE + int'(s);
    return 8'(v);
  endfunction

  function automatic logic [6:0] pix_y(input logic [4:0] c, input logic [SUB_W-1:0] s);
    int v;
    v = OFFSET_Y + int'(c) * CHUNK_SIZE + int'(s);
    return 7'(v);
  endfunction

  function automatic logic [9:0] cell_addr(input logic [4:0] cx, input logic [4:0] cy);
    return 10'(cy) * 10'(GRID_SIZE) + 10'(cx);
  endfunction

  // The cursor wins over the stored bit; out-of-range cursors never match a cell.
  function automatic logic [2:0] cell_colour(input logic hit, input logic bit_set);
    if (hit)
      return CURSOR_COLOUR;
    else if (bit_set)
      return ON_COLOUR;
    else
      return OFF_COLOUR;
  endfunction

  always_comb begin
    nsub_x    = sub_x;
    nsub_y    = sub_y;
    ncell_x   = cell_x;
    ncell_y   = cell_y;
    chunk_end = (sub_x == SUB_LAST) && (sub_y == SUB_LAST);
    last_cell = (cell_x == CELL_LAST) && (cell_y == CELL_LAST);
    if (sub_x == SUB_LAST) begin
      nsub_x = '0;
      nsub_y = sub_y + 1'b1;
    end else begin
      nsub_x = sub_x + 1'b1;
    end
    if (cell_x == CELL_LAST) begin
      ncell_x = '0;
      ncell_y = cell_y + 5'd1;
    end else begin
      ncell_x = cell_x + 5'd1;
    end
  end

  // mem_addr is registered on entry to FETCH so the read data is ready during LATCH.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      cell_x   <= '0;
      cell_y   <= '0;
      sub_x    <= '0;
      sub_y    <= '0;
      cur_x    <= '0;
      cur_y    <= '0;
      mem_addr <= '0;
      vga_x    <= '0;
      vga_y    <= '0;
      colour   <= '0;
      plot     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          plot <= 1'b0;
          done <= 1'b0;
          if (start) begin
            cur_x    <= cursor_x;
            cur_y    <= cursor_y;
            cell_x   <= '0;
            cell_y   <= '0;
            sub_x    <= '0;
            sub_y    <= '0;
            mem_addr <= '0;
            busy     <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_FETCH: state <= S_LATCH;
        S_LATCH: begin
          colour <= cell_colour((cell_x == cur_x) && (cell_y == cur_y), mem_rdata);
          sub_x  <= '0;
          sub_y  <= '0;
          vga_x  <= pix_x(cell_x, '0);
          vga_y  <= pix_y(cell_y, '0);
          plot   <= 1'b1;
          state  <= S_PLOT;
        end
        S_PLOT: begin
          if (!chunk_end) begin
            sub_x <= nsub_x;
            sub_y <= nsub_y;
            vga_x <= pix_x(cell_x, nsub_x);
            vga_y <= pix_y(cell_y, nsub_y);
          end else begin
            plot <= 1'b0;
            if (last_cell) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_FIN;
            end else begin
              cell_x   <= ncell_x;
              cell_y   <= ncell_y;
              mem_addr <= cell_addr(ncell_x, ncell_y);
              state    <= S_FETCH;
            end
          end
        end
        S_FIN: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          plot  <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
